// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared state, parity-mode constants and counter sizing
package parity_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bit counter width; a 2-bit frame still needs one counter bit.
  function automatic int cnt_w(input int frame_bits);
    return (frame_bits <= 2) ? 1 : $clog2(frame_bits);
  endfunction

endpackage

// File: rtl/parity_lane.sv
// rtl/parity_lane.sv - per-lane running XOR, frame verdict and saturating error counter
module parity_lane
  import parity_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             step,
  input  logic             last_beat,
  input  logic             data,
  input  logic             mode_lat,
  output logic             parity_ok,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic acc;
  logic par;
  logic ok;

  assign par = acc ^ data;
  assign ok  = (mode_lat == PAR_EVEN) ? ~par : par;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= 1'b0;
      parity_ok <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      acc       <= 1'b0;
      err_count <= '0;
    end else if (start) begin
      acc <= data;
    end else if (step) begin
      acc <= par;
    end else if (last_beat) begin
      acc       <= 1'b0;
      parity_ok <= ok;
      if (!ok && err_count != ERR_MAX)
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - multi-lane framed parity checker with shared frame FSM
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int FRAME_BITS = 8,
  parameter int ERR_W      = 8,
  localparam int CNT_W     = cnt_w(FRAME_BITS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     valid,
  input  logic [N_LANES-1:0]       data_in,
  input  logic                     mode,
  output logic                     busy,
  output logic [CNT_W-1:0]         bit_count,
  output logic                     frame_done,
  output logic [N_LANES-1:0]       parity_ok,
  output logic [N_LANES*ERR_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             mode_lat;
  logic             is_last;
  logic             start;
  logic             step;
  logic             last_beat;

  assign busy      = (state == ST_COLLECT);
  assign is_last   = (bit_count == LAST_CNT);
  assign start     = valid && !clear && (state == ST_IDLE);
  assign step      = valid && !clear && (state == ST_COLLECT) && !is_last;
  assign last_beat = valid && !clear && (state == ST_COLLECT) && is_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_count  <= '0;
      mode_lat   <= PAR_EVEN;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_count  <= cnt_nxt;
      frame_done <= last_beat;
      if (start)
        mode_lat <= mode;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_count;
    if (clear) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (valid) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_COLLECT;
          cnt_nxt   = CNT_W'(1);
        end
        ST_COLLECT: begin
          if (is_last) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_count + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // One lane slice per serial input; all share the frame position strobes.
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    parity_lane #(
      .ERR_W (ERR_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .start     (start),
      .step      (step),
      .last_beat (last_beat),
      .data      (data_in[l]),
      .mode_lat  (mode_lat),
      .parity_ok (parity_ok[l]),
      .err_count (err_count[l*ERR_W +: ERR_W])
    );
  end

endmodule
